// File: rtl/led_shift_sched_if.sv
// Bundle between the GPIO write path, the LED shifter and status readers.
// The controller takes the slave side; the register path / shifter drive the master side.
interface led_shift_sched_if #(
    parameter int DATA_BITS = 16
);
    logic                 wr_req;
    logic [DATA_BITS-1:0] wr_data;
    logic                 done;
    logic                 err_clr;
    logic                 start;
    logic [DATA_BITS-1:0] pdata;
    logic                 busy;
    logic                 pending;
    logic                 err;
    logic [7:0]           frame_cnt;

    modport slave (
        input  wr_req, wr_data, done, err_clr,
        output start, pdata, busy, pending, err, frame_cnt
    );

    modport master (
        output wr_req, wr_data, done, err_clr,
        input  start, pdata, busy, pending, err, frame_cnt
    );
endinterface

// File: rtl/led_shift_sched.sv
// LED shift frame scheduler: shadows the CPU LED word and launches frames
// into the serial shifter on new data or periodic refresh, with timeout recovery.
module led_shift_sched #(
    parameter int                   DATA_BITS      = 16,
    parameter logic [DATA_BITS-1:0] RESET_VAL      = '0,
    parameter int                   REFRESH_CYCLES = 1_000_000,
    parameter int                   TIMEOUT_CYCLES = 1024,
    parameter int                   GAP_CYCLES     = 4
) (
    input logic              clk,
    input logic              rstn,
    led_shift_sched_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_SHIFT,
        S_GAP
    } state_t;

    localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]     REF_LAST = 24'(REFRESH_CYCLES - 1);
    localparam bit              REF_EN   = (REFRESH_CYCLES != 0);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shadow;
    logic [DATA_BITS-1:0] r_pdata;
    logic                 r_pending;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_err;
    logic [7:0]           r_frame_cnt;
    logic [23:0]          r_ref_cnt;
    logic [15:0]          r_to_cnt;
    logic [GW-1:0]        r_gap_cnt;

    logic w_ref_due;
    logic w_launch;

    // Timer saturates, so a period missed during a long frame stays due.
    assign w_ref_due = REF_EN && (r_ref_cnt >= REF_LAST);
    assign w_launch  = (r_state == S_IDLE) && (r_pending || w_ref_due);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_shadow    <= RESET_VAL;
            r_pdata     <= RESET_VAL;
            r_pending   <= 1'b1;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
            r_ref_cnt   <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            if (r_ref_cnt != '1) begin
                r_ref_cnt <= r_ref_cnt + 24'd1;
            end
            if (bus.err_clr) begin
                r_err <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state   <= S_LAUNCH;
                        r_start   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_pdata   <= r_shadow;
                        r_pending <= 1'b0;
                        r_ref_cnt <= '0;
                        r_to_cnt  <= '0;
                    end
                end
                // The launch cycle counts toward the shifter timeout.
                S_LAUNCH: begin
                    r_state  <= S_SHIFT;
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
                S_SHIFT: begin
                    if (bus.done) begin
                        r_state     <= S_GAP;
                        r_gap_cnt   <= '0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end else if (r_to_cnt >= TO_LAST) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                        r_err     <= 1'b1;
                        r_pending <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A write on the launch edge re-arms pending after it was cleared.
            if (bus.wr_req) begin
                r_shadow  <= bus.wr_data;
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.start     = r_start;
    assign bus.pdata     = r_pdata;
    assign bus.busy      = r_busy;
    assign bus.pending   = r_pending;
    assign bus.err       = r_err;
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_led_shift_sched.sv
// Scoreboard bench for led_shift_sched: a timeline model predicts frame
// launches and status; a monitor matches every start pulse against it.
module tb_led_shift_sched;
    localparam int          DB  = 16;
    localparam logic [15:0] RV  = 16'h002A;
    localparam int          REF = 100;
    localparam int          TO  = 64;
    localparam int          GAP = 4;

    typedef struct {
        int          cyc;
        logic [15:0] pd;
    } frame_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    led_shift_sched_if #(.DATA_BITS(DB)) bus0 ();
    led_shift_sched_if #(.DATA_BITS(DB)) bus1 ();

    led_shift_sched #(
        .DATA_BITS(DB), .RESET_VAL(RV), .REFRESH_CYCLES(REF),
        .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
    ) u_dut (
        .clk(clk), .rstn(rstn), .bus(bus0)
    );

    led_shift_sched #(
        .DATA_BITS(DB), .RESET_VAL(16'h0000), .REFRESH_CYCLES(0),
        .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
    ) u_dut_nr (
        .clk(clk), .rstn(rstn), .bus(bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_rel   = 0;
    int n1_starts  = 0;
    int last_start = 0;
    int prev_start = 0;
    int resp_dly   = 20;
    bit spur_en    = 0;

    // timeline model state
    logic [15:0] m_shadow, m_pdata;
    bit          m_pending, m_err, m_active;
    int          m_fc, m_L, m_free;
    frame_t      exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow  = RV;
        m_pdata   = RV;
        m_pending = 1'b1;
        m_err     = 1'b0;
        m_active  = 1'b0;
        m_fc      = 0;
        m_L       = 0;
        m_free    = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input int t);
        bit     tmo;
        frame_t f;
        tmo = 1'b0;
        if (m_active && t >= m_L + 2) begin
            if (bus0.done) begin
                m_fc     = (m_fc + 1) % 256;
                m_active = 1'b0;
                m_free   = t + GAP + 1;
            end else if (t == m_L + TO) begin
                tmo       = 1'b1;
                m_active  = 1'b0;
                m_pending = 1'b1;
                m_free    = t + GAP + 1;
            end
        end
        if (!m_active && t >= m_free && (m_pending || t - m_L >= REF)) begin
            f.cyc = t;
            f.pd  = m_shadow;
            exp_q.push_back(f);
            m_pdata   = m_shadow;
            m_pending = 1'b0;
            m_L       = t;
            m_active  = 1'b1;
        end
        if (tmo) m_err = 1'b1;
        else if (bus0.err_clr) m_err = 1'b0;
        if (bus0.wr_req) begin
            m_shadow  = bus0.wr_data;
            m_pending = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rstn) model_reset();
        else model_step(cyc);
    end

    always @(negedge rstn) model_reset();

    // monitor: start pulses against the scoreboard, status every cycle
    initial forever begin
        frame_t f;
        bit     m_busy;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_missing @cyc %0d: no start, want start at %0d pdata %h",
                     cyc, exp_q[0].cyc, exp_q[0].pd);
            void'(exp_q.pop_front());
        end
        if (bus0.start) begin
            prev_start = last_start;
            last_start = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL start_extra @cyc %0d: got start pdata %h, want none",
                         cyc, bus0.pdata);
            end else begin
                f = exp_q.pop_front();
                chk("start_cyc", 32'(cyc), 32'(f.cyc));
                chk("start_pdata", 32'(bus0.pdata), 32'(f.pd));
            end
        end
        m_busy = m_active || (cyc + 1 < m_free);
        chk("pdata", 32'(bus0.pdata), 32'(m_pdata));
        chk("busy", 32'(bus0.busy), 32'(m_busy));
        chk("pending", 32'(bus0.pending), 32'(m_pending));
        chk("err", 32'(bus0.err), 32'(m_err));
        chk("frame_cnt", 32'(bus0.frame_cnt), 32'(m_fc));
        if (bus1.start) n1_starts++;
    end

    // shifter model for the main instance
    initial begin
        int k;
        bus0.done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus0.start) begin
                k = resp_dly;
                if (k == 0) begin
                    if ($urandom_range(0, 9) == 0) k = -1;
                    else k = int'($urandom_range(3, 30));
                end
                if (k > 0) begin
                    repeat (k - 1) @(posedge clk);
                    #1 bus0.done = 1'b1;
                    @(posedge clk);
                    #1 bus0.done = 1'b0;
                end
            end else if (spur_en && $urandom_range(0, 39) == 0) begin
                bus0.done = 1'b1;
                @(posedge clk);
                #1 bus0.done = 1'b0;
            end
        end
    end

    // shifter model for the refresh-disabled instance
    initial begin
        bus1.done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.start) begin
                repeat (9) @(posedge clk);
                #1 bus1.done = 1'b1;
                @(posedge clk);
                #1 bus1.done = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] d);
        bus0.wr_req  = 1'b1;
        bus0.wr_data = d;
        tick(1);
        bus0.wr_req  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus0.busy && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_reached", 32'(bus0.busy), 32'(0));
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!bus0.start && n < budget) begin
            tick(1);
            n++;
        end
        chk("start_seen", 32'(bus0.start), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog @cyc %0d: bench did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        model_reset();
        bus0.wr_req = 1'b0; bus0.wr_data = '0; bus0.err_clr = 1'b0;
        bus1.wr_req = 1'b0; bus1.wr_data = '0; bus1.err_clr = 1'b0;
        tick(3);
        chk("rst_pdata", 32'(bus0.pdata), 32'(RV));
        chk("rst_busy", 32'(bus0.busy), 32'(0));
        chk("rst_pending", 32'(bus0.pending), 32'(1));
        chk("rst_start", 32'(bus0.start), 32'(0));
        chk("rst_err", 32'(bus0.err), 32'(0));
        chk("rst_fc", 32'(bus0.frame_cnt), 32'(0));
        rstn = 1'b1;
        n_rel++;

        // initial frame from the reset pending flag
        tick(1);
        chk("init_start", 32'(bus0.start), 32'(1));
        chk("init_pdata", 32'(bus0.pdata), 32'(RV));
        wait_idle(100);
        chk("init_fc", 32'(bus0.frame_cnt), 32'(1));

        // single write launches one edge later, one cycle wide
        tick(3);
        wr(16'h1234);
        tick(1);
        chk("wr_start", 32'(bus0.start), 32'(1));
        chk("wr_pdata", 32'(bus0.pdata), 32'(16'h1234));
        chk("wr_pending", 32'(bus0.pending), 32'(0));
        tick(1);
        chk("wr_start_width", 32'(bus0.start), 32'(0));

        // writes during SHIFT coalesce into one frame
        wr(16'h0001);
        wr(16'h0002);
        wr(16'h0003);
        wait_start(60);
        chk("coal_pdata", 32'(bus0.pdata), 32'(16'h0003));
        chk("coal_pending", 32'(bus0.pending), 32'(0));
        wait_idle(100);

        // shifter never answers: timeout, retry, err_clr
        resp_dly = -1;
        tick(2);
        wr(16'h5A5A);
        tick(1);
        s = cyc;
        n = 0;
        while (!bus0.err && n < 200) begin
            tick(1);
            n++;
        end
        chk("tmo_err", 32'(bus0.err), 32'(1));
        chk("tmo_edge", 32'(cyc - s), 32'(TO));
        resp_dly = 20;
        wait_start(20);
        chk("retry_pdata", 32'(bus0.pdata), 32'(16'h5A5A));
        bus0.err_clr = 1'b1;
        tick(1);
        bus0.err_clr = 1'b0;
        chk("err_clr", 32'(bus0.err), 32'(0));
        wait_idle(100);

        // idle refresh with short frames
        resp_dly = 10;
        tick(350);
        chk("refresh_gap", 32'(last_start - prev_start), 32'(REF));

        // randomized traffic
        resp_dly = 0;
        spur_en  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus0.wr_req  = ($urandom_range(0, 19) == 0);
            bus0.wr_data = 16'($urandom);
            bus0.err_clr = ($urandom_range(0, 49) == 0);
            tick(1);
        end
        bus0.wr_req  = 1'b0;
        bus0.err_clr = 1'b0;
        spur_en  = 1'b0;
        resp_dly = 20;
        tick(40);
        wait_idle(200);

        // asynchronous reset in the middle of a frame
        tick(2);
        wr(16'hBEEF);
        tick(1);
        tick(6);
        chk("mid_pre_busy", 32'(bus0.busy), 32'(1));
        chk("mid_pre_pdata", 32'(bus0.pdata), 32'(16'hBEEF));
        rstn = 1'b0;
        #1;
        chk("mid_pdata", 32'(bus0.pdata), 32'(RV));
        chk("mid_busy", 32'(bus0.busy), 32'(0));
        chk("mid_err", 32'(bus0.err), 32'(0));
        chk("mid_pending", 32'(bus0.pending), 32'(1));
        tick(2);
        rstn = 1'b1;
        n_rel++;
        tick(1);
        chk("post_start", 32'(bus0.start), 32'(1));
        chk("post_pdata", 32'(bus0.pdata), 32'(RV));
        wait_idle(100);
        chk("post_fc", 32'(bus0.frame_cnt), 32'(1));

        // refresh disabled: one frame per reset release only
        tick(20);
        chk("nr_starts", 32'(n1_starts), 32'(n_rel));
        chk("nr_fc", 32'(bus1.frame_cnt), 32'(1));
        chk("nr_err", 32'(bus1.err), 32'(0));

        @(negedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_shift_sched.md
# led_shift_sched

Controller that sequences the serial LED shift engine behind the GPIO port. It keeps a shadow copy of the LED word written by the CPU and launches a shift frame when new data is pending or a periodic refresh falls due. It holds the shifter's parallel input stable for the whole frame, coalesces writes that arrive mid-frame, and recovers from a shifter that never reports completion. It sits between the GPIO register write path and the parallel-to-serial LED shifter.

## Interface
- DATA_BITS, 16, LED word width
- RESET_VAL, 16'h0000, shadow/pdata value after reset
- REFRESH_CYCLES, 1_000_000, launch-to-launch refresh period in clk cycles; 0 disables refresh; 24-bit counter
- TIMEOUT_CYCLES, 1024, max cycles in SHIFT without done; 16-bit counter, must be ≥1
- GAP_CYCLES, 4, idle cycles forced after each frame (latch settle); must be ≥1

- clk  in  1  system clock, all state updates on posedge
- rstn  in  1  reset, asynchronous, active-low
- wr_req  in  1  one-cycle CPU write strobe for the LED word
- wr_data  in  DATA_BITS  LED word, sampled when wr_req=1
- done  in  1  one-cycle completion pulse from shifter
- err_clr  in  1  clears err
- start  out  1  one-cycle launch pulse to shifter
- pdata  out  DATA_BITS  parallel word to shifter, registered
- busy  out  1  high in LAUNCH, SHIFT, GAP
- pending  out  1  shadow holds data not yet launched
- err  out  1  sticky timeout flag
- frame_cnt  out  8  completed frames (done received), wraps 255→0

## Operation
- States: IDLE, LAUNCH, SHIFT, GAP. Reset state IDLE.
- Reset values: start=0, pdata=RESET_VAL, shadow=RESET_VAL, busy=0, pending=1 (forces one initial frame), err=0, frame_cnt=0, refresh timer=0.
- wr_req, any state: shadow←wr_data, pending←1. Multiple writes before launch coalesce; the last one wins.
- IDLE→LAUNCH when pending=1 or refresh_due=1. On this edge: pdata←shadow, pending←0, refresh timer←0, refresh_due←0. If wr_req occurs on the same edge, shadow takes the new word and pending ends at 1 (set wins over clear). pdata keeps the pre-write shadow.
- LAUNCH: start=1 for exactly this one cycle, then →SHIFT unconditionally. Timeout counter←0.
- SHIFT: if done=1 → GAP, frame_cnt+1. Else if the timeout counter reaches TIMEOUT_CYCLES-1 → GAP, err←1, pending←1 (retry same shadow). Else the counter increments.
- GAP: count GAP_CYCLES cycles, then →IDLE.
- pdata changes only on the IDLE→LAUNCH edge. It is stable from start through the end of GAP.
- done outside SHIFT is ignored, including for frame_cnt.
- Refresh timer: increments every cycle and saturates; cleared at each launch. refresh_due sets when the timer reaches REFRESH_CYCLES-1. With REFRESH_CYCLES=0 it never sets.
- err_clr clears err. If a timeout occurs on the same edge, set wins.
- Priority at IDLE: a single launch serves both pending and refresh_due.

## Timing
- wr_req at edge k in IDLE, no frame active: LAUNCH at edge k+1 (start high in cycle k+1→k+2), SHIFT at k+2.
- After reset release: first start pulse in the second cycle after rstn rises (pending=1 at reset).
- done at edge d: GAP from d. IDLE at d+GAP_CYCLES. Earliest next start at d+GAP_CYCLES+1.
- Refresh with short frames: consecutive refresh start pulses are exactly REFRESH_CYCLES cycles apart. If a frame+gap outlasts the period, the launch occurs at the first IDLE cycle.
- Timeout: from start at cycle s, err rises at edge s+TIMEOUT_CYCLES.
- rstn low mid-frame: outputs take reset values immediately, asynchronously. An in-progress frame is abandoned, and one fresh frame with RESET_VAL follows release.

## Test plan
- Reset with RESET_VAL=16'h002A, done returned 20 cycles after start → one start pulse, pdata=002A, frame_cnt=1, busy low GAP_CYCLES after done.
- IDLE, wr_req with 16'h1234 → start exactly 1 cycle wide one edge later, pdata=1234 held until IDLE, pending=0.
- During SHIFT, wr_req with 16'h0001, 16'h0002, 16'h0003 → after done+GAP exactly one further start with pdata=0003; no extra frames.
- TIMEOUT_CYCLES=64, done never returned → err=1 at start+64, retry start after GAP with same pdata. err_clr clears err; frame_cnt unchanged.
- REFRESH_CYCLES=100, no writes, done 10 cycles after each start → start pulses exactly 100 cycles apart. REFRESH_CYCLES=0 → no start after the initial frame.
- rstn pulled low 5 cycles into SHIFT with pdata=16'hBEEF → pdata=RESET_VAL, busy=0, err=0 immediately. After release, one new frame with RESET_VAL.
